ram_bist_ctrl: RTL and testbench

Built-in self-test initiator for the synchronous `dual_port_ram`. On a `start` pulse it fills every location through port A with LFSR-generated data, then reads every location back through port B and compares each word against a regenerated copy of the same sequence. Pass/fail, the error count and the first failing address are reported. It sits between system control logic and the RAM and owns both RAM ports while `busy` is high.

---
 rtl/ram_bist_pkg.sv | 13 +
 rtl/bist_lfsr.sv | 29 ++
 rtl/ram_bist_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding and LFSR step for the RAM BIST controller
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} bist_state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Galois step: shift right, fold the taps back in when bit 0 falls out
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: 32-bit Galois LFSR with synchronous seed load and step enable
module bist_lfsr
    import ram_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    // next value: a load wins over an advance so a reseed is never lost
    always_comb begin
        value_d = load ? seed : advance ? lfsr_next(value_q) : value_q;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: fills a dual-port RAM with LFSR data on port A, reads it back on port B and counts mismatches
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  cs_a,
    output logic                  cs_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic                  oe_a,
    output logic                  oe_b,
    output logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b_out
);

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pvalid_q, pvalid_d;
    logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic                  pass_q, pass_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_a_q, cs_a_d;
    logic                  we_a_q, we_a_d;
    logic                  oe_a_q, oe_a_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic                  cs_b_q, cs_b_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic                  lfsr_load, lfsr_adv;
    logic [31:0]           lfsr, lfsr_nv;
    logic                  mismatch, clr, wr, rd;

    bist_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

    // sequencing: the address counter wraps by itself at N-1, which is also the phase boundary
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d   = start ? WRITE : IDLE;
                lfsr_load = start;
                cnt_d     = '0;
            end
            WRITE, READ: begin
                lfsr_adv = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d   = (state_q == WRITE) ? READ : DRAIN;
                    lfsr_load = (state_q == WRITE);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // compare pipe, result registers and next values of the registered RAM-side outputs
    always_comb begin
        lfsr_nv          = lfsr_load ? SEED : lfsr_adv ? lfsr_next(lfsr) : lfsr;
        mismatch         = pvalid_q && (data_b_out != exp_q);
        clr              = (state_q == IDLE) && start;
        wr               = (state_d == WRITE);
        rd               = (state_d == READ);
        exp_d            = (state_q == READ) ? lfsr[DATA_WIDTH-1:0] : exp_q;
        paddr_d          = (state_q == READ) ? cnt_q : paddr_q;
        pvalid_d         = (state_q == READ);
        err_count_d      = clr ? '0 : err_count_q + {{ADDR_WIDTH{1'b0}}, mismatch};
        first_err_addr_d = clr ? '0 : (mismatch && err_count_q == '0) ? paddr_q : first_err_addr_q;
        pass_d           = clr ? 1'b0 : (state_d == DONE) ? (err_count_d == '0) : pass_q;
        busy_d           = (state_d != IDLE);
        done_d           = (state_d == DONE);
        cs_a_d           = wr;
        we_a_d           = wr;
        oe_a_d           = !wr;
        addr_a_d         = wr ? cnt_d : '0;
        data_a_d         = wr ? lfsr_nv[DATA_WIDTH-1:0] : '0;
        cs_b_d           = rd;
        addr_b_d         = rd ? cnt_d : '0;
    end

    // FSM and registered outputs; reset aborts any test in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            exp_q            <= '0;
            paddr_q          <= '0;
            pvalid_q         <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pass_q           <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            cs_a_q           <= 1'b0;
            we_a_q           <= 1'b0;
            oe_a_q           <= 1'b1;
            addr_a_q         <= '0;
            data_a_q         <= '0;
            cs_b_q           <= 1'b0;
            addr_b_q         <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            exp_q            <= exp_d;
            paddr_q          <= paddr_d;
            pvalid_q         <= pvalid_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            pass_q           <= pass_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            cs_a_q           <= cs_a_d;
            we_a_q           <= we_a_d;
            oe_a_q           <= oe_a_d;
            addr_a_q         <= addr_a_d;
            data_a_q         <= data_a_d;
            cs_b_q           <= cs_b_d;
            addr_b_q         <= addr_b_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign cs_a           = cs_a_q;
    assign we_a           = we_a_q;
    assign oe_a           = oe_a_q;
    assign addr_a         = addr_a_q;
    assign data_a         = data_a_q;
    assign cs_b           = cs_b_q;
    assign addr_b         = addr_b_q;
    assign we_b           = 1'b0;
    assign oe_b           = 1'b1;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed and randomized fault-injection runs against a behavioural RAM and result model
module tb_ram_bist_ctrl;

    localparam int          AW   = 6;
    localparam int          DW   = 32;
    localparam int          N    = 64;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr, addr_a, addr_b;
    logic          cs_a, cs_b, we_a, we_b, oe_a, oe_b;
    logic [DW-1:0] data_a, data_b_out;

    logic [DW-1:0] mem    [N];
    logic [DW-1:0] set_m  [N];
    logic [DW-1:0] clr_m  [N];
    logic [DW-1:0] flip_m [N];

    int checks   = 0;
    int failures = 0;

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(SEED)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .cs_a           (cs_a),
        .cs_b           (cs_b),
        .we_a           (we_a),
        .we_b           (we_b),
        .oe_a           (oe_a),
        .oe_b           (oe_b),
        .data_a         (data_a),
        .data_b_out     (data_b_out)
    );

    always #5 clk = ~clk;

    // synchronous dual-port RAM with per-address stuck-at and bit-flip faults on the read path
    always @(posedge clk) begin
        if (cs_a && we_a && !oe_a) mem[addr_a] <= data_a;
        if (cs_b && oe_b && !we_b) data_b_out <= ((mem[addr_b] | set_m[addr_b]) & ~clr_m[addr_b]) ^ flip_m[addr_b];
    end

    // i-th word of the pseudo-random sequence started from SEED
    function automatic logic [31:0] word_at(input int i);
        logic [31:0] v;
        v = SEED;
        repeat (i) v = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
        return v;
    endfunction

    // port picture expected in cycle T0+c of a test (c=0 or past DONE: idle)
    function automatic logic [51:0] exp_vec(input int c);
        logic          w, r;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] d;
        w  = (c >= 1 && c <= N);
        r  = (c > N && c <= 2 * N);
        aa = w ? AW'(c - 1) : '0;
        ab = r ? AW'(c - N - 1) : '0;
        d  = w ? word_at(c - 1) : '0;
        return {(c >= 1 && c <= 2 * N + 2), (c == 2 * N + 2), w, w, !w, aa, d, r, 1'b0, 1'b1, ab};
    endfunction

    function automatic logic [51:0] act_vec();
        return {busy, done, cs_a, we_a, oe_a, addr_a, data_a, cs_b, we_b, oe_b, addr_b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            set_m[a]  = '0;
            clr_m[a]  = '0;
            flip_m[a] = '0;
        end
    endtask

    // expected error count and first failing address from the fault tables
    task automatic expect_result(output int e, output int f);
        logic [31:0] w, r;
        e = 0;
        f = 0;
        for (int a = 0; a < N; a++) begin
            w = word_at(a);
            r = ((w | set_m[a]) & ~clr_m[a]) ^ flip_m[a];
            if (r != w) begin
                if (e == 0) f = a;
                e++;
            end
        end
    endtask

    // one test: optional extra start pulses s1/s2, optional reset at abort_at, optional chained start after DONE
    task automatic run(input bit pre, input int abort_at, input int s1, input int s2, input bit chain);
        int e, f;
        expect_result(e, f);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        for (int c = 1; c <= 2 * N + 3; c++) begin
            @(negedge clk);
            start = (c == s1) || (c == s2) || (chain && c == 2 * N + 3);
            if (abort_at > 0 && c == abort_at + 1) begin
                chk("abort_ports", 64'(act_vec()), 64'(exp_vec(0)));
                chk("abort_result", {pass, err_count, first_err_addr}, '0);
                rst = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("abort_quiet", {busy, done}, 2'b00);
                end
                break;
            end
            rst = (c == abort_at);
            chk("ports", 64'(act_vec()), 64'(exp_vec(c)));
            if (c == 1) chk("first_word", data_a, SEED);
            if (c >= 2 * N + 2) chk("result", {pass, err_count, first_err_addr}, {e == 0, (AW + 1)'(e), AW'(f)});
        end
    endtask

    initial begin
        int k;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ports", 64'(act_vec()), 64'(exp_vec(0)));
        chk("reset_result", {pass, err_count, first_err_addr}, '0);
        rst = 1'b0;

        run(1'b0, 0, 0, 0, 1'b0);

        set_m[5] = 32'h1;
        run(1'b0, 0, 0, 0, 1'b0);

        clear_faults();
        clr_m[5] = 32'h1;
        run(1'b0, 0, 0, 0, 1'b0);

        clear_faults();
        flip_m[9]  = 32'h1 << $urandom_range(0, 31);
        flip_m[40] = $urandom | 32'h8000_0000;
        run(1'b0, 0, 0, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            clear_faults();
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                flip_m[$urandom_range(0, N - 1)] = $urandom;
                set_m[$urandom_range(0, N - 1)]  = $urandom & $urandom;
                clr_m[$urandom_range(0, N - 1)]  = $urandom & $urandom;
            end
            run(1'b0, 0, 0, 0, 1'b0);
        end

        clear_faults();
        for (int a = 0; a < N; a++) flip_m[a] = $urandom | 32'h1;
        run(1'b0, 0, 0, 0, 1'b0);

        clear_faults();
        run(1'b0, 70, 0, 0, 1'b0);
        run(1'b0, 0, 0, 0, 1'b0);

        flip_m[$urandom_range(0, N - 1)] = 32'h4;
        run(1'b0, 0, 10, 2 * N + 2, 1'b1);
        clear_faults();
        run(1'b1, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
